// File: rtl/rom_ddram_bridge.sv
// Cartridge ROM port onto the HPS DDR3 Avalon master: toggle-handshake 16-bit
// download writes in, 64-bit ROM line reads out through a one-line cache.
module rom_ddram_bridge #(
  parameter logic [28:0] BASE_ADDR = 29'h0300000,
  parameter int          AW        = 25
) (
  input  logic          DDRAM_CLK,
  input  logic          reset,
  input  logic          DDRAM_BUSY,
  output logic [7:0]    DDRAM_BURSTCNT,
  output logic [28:0]   DDRAM_ADDR,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE,
  input  logic [AW-1:0] wraddr,
  input  logic [15:0]   din,
  input  logic          we_req,
  output logic          we_ack,
  input  logic [AW-1:0] rdaddr,
  output logic [63:0]   dout,
  input  logic          rd_req,
  output logic          rd_ack
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

  state_t        r_state, w_next;
  logic [AW-4:0] r_tag;
  logic          r_valid;
  logic [63:0]   r_cache;

  logic          w_we_pend, w_rd_pend, w_hit;
  logic          w_start_wr, w_start_rd, w_serve_hit, w_wr_done, w_rd_sent, w_rd_done;
  logic [28:0]   w_wr_addr, w_rd_addr;
  logic [7:0]    w_be;
  logic          w_unused;

  assign DDRAM_BURSTCNT = 8'd1;
  assign w_we_pend      = we_req != we_ack;
  assign w_rd_pend      = rd_req != rd_ack;
  assign w_hit          = r_valid && (r_tag == rdaddr[AW-1:3]);
  assign w_wr_addr      = BASE_ADDR + 29'(wraddr[AW-1:3]);
  assign w_rd_addr      = BASE_ADDR + 29'(rdaddr[AW-1:3]);
  assign w_be           = 8'b11 << {wraddr[2:1], 1'b0};
  // Sub-word address bits that never select anything.
  assign w_unused       = ^{wraddr[0], rdaddr[2:0]};

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_we_pend)             w_next = WRITE;
               else if (w_rd_pend && !w_hit) w_next = READ;
      WRITE:   if (!DDRAM_BUSY)           w_next = IDLE;
      READ:    if (!DDRAM_BUSY)           w_next = RWAIT;
      RWAIT:   if (DDRAM_DOUT_READY)      w_next = IDLE;
      default:                            w_next = IDLE;
    endcase
  end

  // Writes win over reads when both are pending in the same cycle.
  always_comb begin
    w_start_wr  = (r_state == IDLE) && w_we_pend;
    w_start_rd  = (r_state == IDLE) && !w_we_pend && w_rd_pend && !w_hit;
    w_serve_hit = (r_state == IDLE) && !w_we_pend && w_rd_pend && w_hit;
    w_wr_done   = (r_state == WRITE) && !DDRAM_BUSY;
    w_rd_sent   = (r_state == READ)  && !DDRAM_BUSY;
    w_rd_done   = (r_state == RWAIT) && DDRAM_DOUT_READY;
  end

  always_ff @(posedge DDRAM_CLK or posedge reset) begin
    if (reset) begin
      we_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      dout       <= '0;
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_cache    <= '0;
    end else begin
      if (w_start_wr) begin
        DDRAM_ADDR <= w_wr_addr;
        DDRAM_DIN  <= {4{din}};
        DDRAM_BE   <= w_be;
        DDRAM_WE   <= 1'b1;
        r_valid    <= 1'b0;
      end
      if (w_start_rd) begin
        DDRAM_ADDR <= w_rd_addr;
        DDRAM_RD   <= 1'b1;
        r_tag      <= rdaddr[AW-1:3];
      end
      if (w_serve_hit) begin
        dout   <= r_cache;
        rd_ack <= rd_req;
      end
      if (w_wr_done) begin
        DDRAM_WE <= 1'b0;
        we_ack   <= we_req;
      end
      if (w_rd_sent) DDRAM_RD <= 1'b0;
      if (w_rd_done) begin
        r_cache <= DDRAM_DOUT;
        dout    <= DDRAM_DOUT;
        r_valid <= 1'b1;
        rd_ack  <= rd_req;
      end
    end
  end
endmodule
